// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over NUM_CH parallel lanes with valid/ready on both sides.
// Horizontal pair-max is held in a register; vertical max uses a half-width line buffer.
module maxpool_2x2_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 16,
    parameter int MAX_W      = 416,
    parameter int MAX_H      = 416,
    parameter int SIGNED     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [$clog2(MAX_W+1)-1:0]       cfg_width,
    input  logic [$clog2(MAX_H+1)-1:0]       cfg_height,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*NUM_CH-1:0]     in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*NUM_CH-1:0]     out_data,
    output logic                             frame_done
);

    localparam int WW       = $clog2(MAX_W + 1);
    localparam int HW       = $clog2(MAX_H + 1);
    localparam int VW       = DATA_WIDTH * NUM_CH;
    localparam int LB_DEPTH = MAX_W / 2;
    localparam int LBA      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    function automatic logic [DATA_WIDTH-1:0] lane_max(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic a_gt;
        if (SIGNED != 0) begin
            a_gt = $signed(a) > $signed(b);
        end else begin
            a_gt = a > b;
        end
        return a_gt ? a : b;
    endfunction

    function automatic logic [VW-1:0] vec_max(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c*DATA_WIDTH +: DATA_WIDTH] = lane_max(a[c*DATA_WIDTH +: DATA_WIDTH],
                                                     b[c*DATA_WIDTH +: DATA_WIDTH]);
        end
        return r;
    endfunction

    logic [WW-1:0]  col_q, col_d, width_q, width_d, eff_w_s;
    logic [HW-1:0]  row_q, row_d, height_q, height_d, eff_h_s;
    logic [VW-1:0]  hold_q, hold_d, out_data_q, out_data_d, hmax_s, lb_rd_s;
    logic           out_valid_q, out_valid_d, frame_done_q, frame_done_d;
    logic           accept_s, first_s, last_col_s, last_row_s, pair_col_s, lb_we_s;
    logic [LBA-1:0] lb_addr_s;
    logic [VW-1:0]  linebuf_q [LB_DEPTH];

    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

    // Beat decode: config is taken live from the ports on the first beat of a frame.
    always_comb begin
        accept_s   = in_valid && in_ready;
        first_s    = (col_q == WW'(0)) && (row_q == HW'(0));
        eff_w_s    = first_s ? cfg_width  : width_q;
        eff_h_s    = first_s ? cfg_height : height_q;
        last_col_s = (col_q == eff_w_s - WW'(1));
        last_row_s = (row_q == eff_h_s - HW'(1));
        pair_col_s = (col_q < {eff_w_s[WW-1:1], 1'b0});
        lb_addr_s  = LBA'(col_q >> 1);
        lb_rd_s    = linebuf_q[lb_addr_s];
        hmax_s     = vec_max(hold_q, in_data);
        lb_we_s    = accept_s && col_q[0] && !row_q[0];
    end

    // Next-state for counters, config, hold register and the single-entry output register.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        width_d      = width_q;
        height_d     = height_q;
        hold_d       = hold_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = accept_s && last_col_s && last_row_s;

        if (accept_s) begin
            if (first_s) begin
                width_d  = cfg_width;
                height_d = cfg_height;
            end else begin
                width_d  = width_q;
                height_d = height_q;
            end
            if (last_col_s) begin
                col_d = WW'(0);
                if (last_row_s) begin
                    row_d = HW'(0);
                end else begin
                    row_d = row_q + HW'(1);
                end
            end else begin
                col_d = col_q + WW'(1);
                row_d = row_q;
            end
            if (!col_q[0] && pair_col_s) begin
                hold_d = in_data;
            end else begin
                hold_d = hold_q;
            end
        end else begin
            col_d = col_q;
        end

        // Odd column always has a partner; odd row always has a partner above it.
        if (accept_s && col_q[0] && row_q[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = vec_max(hmax_s, lb_rd_s);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= WW'(0);
            row_q        <= HW'(0);
            width_q      <= WW'(0);
            height_q     <= HW'(0);
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            width_q      <= width_d;
            height_q     <= height_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer of horizontal maxima: written on even rows, read on odd rows.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            linebuf_q[lb_addr_s] <= hmax_s;
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Randomized bench for maxpool_2x2_stream: a signed and an unsigned instance see the same
// stream and are compared against a frame-level pooling model and an output-occupancy model.
module tb_maxpool_2x2_stream;

    localparam int DW = 16;
    localparam int NCH = 4;
    localparam int MW = 16;
    localparam int MH = 8;
    localparam int VW = DW * NCH;
    localparam int WW = $clog2(MW + 1);
    localparam int HW = $clog2(MH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] cfg_width;
    logic [HW-1:0] cfg_height;
    logic          in_valid;
    logic [VW-1:0] in_data;
    logic          out_ready;
    logic          in_ready_s, in_ready_u, out_valid_s, out_valid_u, fd_s, fd_u;
    logic [VW-1:0] out_data_s, out_data_u;

    int total = 0;
    int bad = 0;

    logic [VW-1:0] pix [MW*MH];
    logic [DW-1:0] win [4] = '{16'hFFFB, 16'hFFFE, 16'hFFF8, 16'hFFFF};

    always #5 clk = ~clk;

    maxpool_2x2_stream #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_W(MW), .MAX_H(MH), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .frame_done(fd_s));

    maxpool_2x2_stream #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_W(MW), .MAX_H(MH), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .frame_done(fd_u));

    function automatic longint lane_val(input logic [DW-1:0] v, input bit sgn);
        if (sgn) return longint'($signed(v));
        return longint'(v);
    endfunction

    // Pooled pixel (ox,oy) of the frame currently in pix[], for every lane.
    function automatic logic [VW-1:0] ref_pool(input int w, input int ox, input int oy, input bit sgn);
        logic [VW-1:0] r;
        logic [DW-1:0] bv, v;
        longint best;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            bv = pix[(2*oy)*w + 2*ox][c*DW +: DW];
            best = lane_val(bv, sgn);
            for (int k = 1; k < 4; k++) begin
                v = pix[(2*oy + k/2)*w + 2*ox + k%2][c*DW +: DW];
                if (lane_val(v, sgn) > best) begin
                    best = lane_val(v, sgn);
                    bv = v;
                end
            end
            r[c*DW +: DW] = bv;
        end
        return r;
    endfunction

    task automatic fill(input int w, input int h, input int mode);
        logic [DW-1:0] v;
        int col, row;
        for (int idx = 0; idx < w*h; idx++) begin
            col = idx % w;
            row = idx / w;
            for (int c = 0; c < NCH; c++) begin
                case (mode)
                    0: v = DW'(idx * (c + 1));
                    1: v = DW'(col + 10*row + 100*c);
                    2: v = DW'($urandom);
                    3: v = (c == 0) ? win[idx % 4] : DW'($urandom);
                    default: v = '0;
                endcase
                pix[idx][c*DW +: DW] = v;
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input int stall, input string name);
        logic [VW-1:0] exp_s[$];
        logic [VW-1:0] exp_u[$];
        int idx, cyc, col, row;
        bit model_ov, fd_pending, acc, pop, produce;
        idx = 0; cyc = 0; model_ov = 1'b0; fd_pending = 1'b0;
        for (int oy = 0; oy < h/2; oy++) begin
            for (int ox = 0; ox < w/2; ox++) begin
                exp_s.push_back(ref_pool(w, ox, oy, 1'b1));
                exp_u.push_back(ref_pool(w, ox, oy, 1'b0));
            end
        end
        cfg_width  = WW'(w);
        cfg_height = HW'(h);
        while ((idx < w*h || model_ov || fd_pending) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (idx > 0) begin
                cfg_width  = WW'($urandom_range(2, MW));
                cfg_height = HW'($urandom_range(2, MH));
            end
            case (stall)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid = (idx < w*h) && (stall < 2 || $urandom_range(0, 3) != 0);
            in_data  = (idx < w*h) ? pix[idx] : '0;
            #1;
            total++;
            if (fd_s !== fd_pending || fd_u !== fd_pending) begin
                bad++;
                $display("FAIL %s frame_done beat=%0d got=%b/%b want=%b", name, idx, fd_s, fd_u, fd_pending);
            end
            total++;
            if (out_valid_s !== model_ov || out_valid_u !== model_ov) begin
                bad++;
                $display("FAIL %s out_valid beat=%0d got=%b/%b want=%b", name, idx, out_valid_s, out_valid_u, model_ov);
            end
            total++;
            if (in_ready_s !== (!model_ov || out_ready) || in_ready_u !== (!model_ov || out_ready)) begin
                bad++;
                $display("FAIL %s in_ready beat=%0d got=%b/%b want=%b", name, idx, in_ready_s, in_ready_u,
                         (!model_ov || out_ready));
            end
            if (model_ov && exp_s.size() > 0) begin
                total++;
                if (out_data_s !== exp_s[0] || out_data_u !== exp_u[0]) begin
                    bad++;
                    $display("FAIL %s out_data got=%h/%h want=%h/%h", name, out_data_s, out_data_u, exp_s[0], exp_u[0]);
                end
            end
            pop = model_ov && out_ready;
            acc = in_valid && (!model_ov || out_ready);
            col = idx % w;
            row = idx / w;
            produce = acc && (col % 2 == 1) && (row % 2 == 1) && (col < 2*(w/2)) && (row < 2*(h/2));
            if (pop && exp_s.size() > 0) begin
                void'(exp_s.pop_front());
                void'(exp_u.pop_front());
            end
            model_ov = produce ? 1'b1 : (pop ? 1'b0 : model_ov);
            fd_pending = acc && (idx == w*h - 1);
            if (acc) idx++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (idx != w*h || exp_s.size() != 0 || cyc >= 3000) begin
            bad++;
            $display("FAIL %s completion beats=%0d/%0d pending_outputs=%0d cycles=%0d", name, idx, w*h, exp_s.size(), cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cfg_width = WW'(4); cfg_height = HW'(4);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (out_valid_s !== 1'b0 || out_valid_u !== 1'b0 || out_data_s !== '0 || out_data_u !== '0 ||
            fd_s !== 1'b0 || fd_u !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got valid=%b/%b data=%h/%h done=%b/%b want all 0",
                     out_valid_s, out_valid_u, out_data_s, out_data_u, fd_s, fd_u);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready_s !== 1'b1 || in_ready_u !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b/%b want=1", in_ready_s, in_ready_u);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_basic();
        fill(4, 4, 0);
        total++;
        if (ref_pool(4, 0, 0, 1'b0) !== {16'd20, 16'd15, 16'd10, 16'd5}) begin
            bad++;
            $display("FAIL model_4x4 got=%h want lane0=5", ref_pool(4, 0, 0, 1'b0));
        end
        run_frame(4, 4, 0, "basic_4x4");
    endtask

    task automatic test_stall();
        fill(4, 4, 0);
        run_frame(4, 4, 1, "stall_4x4");
    endtask

    task automatic test_odd_dims();
        fill(5, 3, 1);
        run_frame(5, 3, 0, "odd_5x3");
        fill(7, 5, 2);
        run_frame(7, 5, 2, "odd_7x5");
    endtask

    task automatic test_signed();
        fill(2, 2, 3);
        run_frame(2, 2, 0, "signed_window");
        fill(4, 4, 2);
        run_frame(4, 4, 2, "signed_random");
    endtask

    task automatic test_lanes();
        fill(6, 4, 0);
        run_frame(6, 4, 2, "lanes_6x4");
    endtask

    task automatic test_mid_reset();
        int n;
        n = 0;
        fill(4, 4, 2);
        cfg_width = WW'(4); cfg_height = HW'(4);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 50 && n < 6; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pix[n];
            #1;
            if (in_ready_s) n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid_s !== 1'b1 || n != 6) begin
            bad++;
            $display("FAIL midreset_partial got valid=%b beats=%0d want valid=1 beats=6", out_valid_s, n);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid_s !== 1'b0 || out_valid_u !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abort got valid=%b/%b want=0", out_valid_s, out_valid_u);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        fill(4, 4, 2);
        run_frame(4, 4, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        fill(2, 2, 2);
        run_frame(2, 2, 0, "b2b_2x2");
        fill(6, 2, 2);
        run_frame(6, 2, 0, "b2b_6x2");
    endtask

    task automatic test_random();
        int w, h;
        for (int f = 0; f < 8; f++) begin
            w = $urandom_range(2, MW);
            h = $urandom_range(2, MH);
            fill(w, h, 2);
            run_frame(w, h, 2, "random");
        end
        fill(MW, MH, 2);
        run_frame(MW, MH, 1, "max_size");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_odd_dims();
        test_signed();
        test_lanes();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
